// File: rtl/mpsoc_pkg.sv
// Shared MPSoC AHB3 encodings (HTRANS/HBURST/HSIZE/HRESP) and the DMA master state type.
package mpsoc_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {IDLE, ADDR, LAST, DONE} dma_state_t;

endpackage

// File: rtl/mpsoc_ahb3_dma_master.sv
// AHB3-Lite DMA master: one command becomes an INCR burst of full-width beats, read or write.
// Build option MPSOC_AHB3_DMA_1KB_SPLIT_EN restarts the burst with NONSEQ at every 1KB boundary.
module mpsoc_ahb3_dma_master
    import mpsoc_pkg::*;
#(
    parameter int         HADDR_SIZE = 64,
    parameter int         HDATA_SIZE = 32,
    parameter int         LEN_SIZE   = 16,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic [LEN_SIZE-1:0]   cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [HDATA_SIZE-1:0] wr_data,
    output logic                  rd_valid,
    output logic [HDATA_SIZE-1:0] rd_data,
    output logic                  done,
    output logic                  error,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output dma_state_t            dbg_state
);

    localparam logic [HADDR_SIZE-1:0] ADDR_STEP = HADDR_SIZE'(HDATA_SIZE / 8);
    localparam logic [2:0]            HSIZE_VAL = 3'($clog2(HDATA_SIZE / 8));

    dma_state_t            state_q,  state_d;
    logic [HADDR_SIZE-1:0] haddr_q,  haddr_d;
    logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
    logic                  hwrite_q, hwrite_d;
    logic [LEN_SIZE-1:0]   beats_q,  beats_d;
    logic                  first_q,  first_d;
    logic                  dphase_q, dphase_d;
    logic                  err1_q,   err1_d;
    logic                  error_q,  error_d;

    logic [1:0] trans;
    logic       issue;
    logic       split;

`ifdef MPSOC_AHB3_DMA_1KB_SPLIT_EN
    assign split = (haddr_q[9:0] == 10'd0);
`else
    assign split = 1'b0;
`endif

    // Address phase is combinational on wr_valid so a write beat is offered
    // the same cycle its data is accepted; the accepted data is then registered
    // into the following data phase.
    always_comb begin
        trans = HTRANS_IDLE;
        if (state_q == ADDR && !err1_q && beats_q != '0) begin
            if (hwrite_q && !wr_valid) begin
                trans = first_q ? HTRANS_IDLE : HTRANS_BUSY;
            end else if (first_q || split) begin
                trans = HTRANS_NONSEQ;
            end else begin
                trans = HTRANS_SEQ;
            end
        end
    end

    assign issue = (state_q == ADDR) && HREADY && trans[1];

    // Streams: cmd and wr transfer on valid & ready in the same cycle; the
    // source holds valid and payload stable until ready. rd has no backpressure.
    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == ADDR) && HREADY && (beats_q != '0) && hwrite_q && !err1_q;
    assign rd_valid  = dphase_q && !hwrite_q && HREADY && !HRESP;
    assign rd_data   = HRDATA;
    assign done      = (state_q == DONE);
    assign error     = (state_q == DONE) && error_q;

    assign HTRANS    = trans;
    assign HSEL      = (trans != HTRANS_IDLE);
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = HSIZE_VAL;
    assign HBURST    = HBURST_INCR;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        hwrite_d = hwrite_q;
        beats_d  = beats_q;
        first_d  = first_q;
        error_d  = error_q;
        err1_d   = 1'b0;
        dphase_d = issue ? 1'b1 : (HREADY ? 1'b0 : dphase_q);
        if (wr_valid && wr_ready) begin
            hwdata_d = wr_data;
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    haddr_d  = cmd_addr;
                    beats_d  = cmd_len;
                    hwrite_d = cmd_write;
                    first_d  = 1'b1;
                    error_d  = 1'b0;
                    state_d  = (cmd_len == '0) ? DONE : ADDR;
                end
            end
            ADDR, LAST: begin
                // Two-cycle ERROR response: the first cycle (HREADY low) forces
                // IDLE onto the bus next, the second (HREADY high) ends the command.
                if (err1_q) begin
                    if (HREADY) begin
                        state_d = DONE;
                        error_d = 1'b1;
                    end else begin
                        err1_d = 1'b1;
                    end
                end else if (dphase_q && HRESP && !HREADY) begin
                    err1_d = 1'b1;
                end else if (state_q == LAST) begin
                    if (!dphase_q || HREADY) begin
                        state_d = DONE;
                    end
                end else if (issue) begin
                    haddr_d = haddr_q + ADDR_STEP;
                    beats_d = beats_q - LEN_SIZE'(1);
                    first_d = 1'b0;
                    if (beats_q == LEN_SIZE'(1)) begin
                        state_d = LAST;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hwrite_q <= 1'b0;
            beats_q  <= '0;
            first_q  <= 1'b0;
            dphase_q <= 1'b0;
            err1_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            hwrite_q <= hwrite_d;
            beats_q  <= beats_d;
            first_q  <= first_d;
            dphase_q <= dphase_d;
            err1_q   <= err1_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_mpsoc_ahb3_dma_master.sv
// Directed bench for mpsoc_ahb3_dma_master with a small zero/variable-wait SRAM slave model.
module tb_mpsoc_ahb3_dma_master;
    import mpsoc_pkg::*;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          done, error;
    logic          HSEL, HWRITE, HMASTLOCK;
    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA, HRDATA;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [1:0]    HTRANS;
    logic          HREADY, HRESP;
    dma_state_t    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] mem [0:1023];
    logic          sl_dp_valid;
    logic          sl_dp_write;
    logic [9:0]    sl_dp_idx;

    mpsoc_ahb3_dma_master dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .error(error),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .dbg_state(dbg_state)
    );

    always #5 HCLK = ~HCLK;

    // SRAM slave model: HREADY/HRESP come from the bench, data phase follows an accepted address.
    always @(posedge HCLK) begin
        if (HRESET) begin
            sl_dp_valid <= 1'b0;
        end else if (HREADY) begin
            if (sl_dp_valid && sl_dp_write && !HRESP) mem[sl_dp_idx] <= HWDATA;
            sl_dp_valid <= HSEL && HTRANS[1];
            sl_dp_write <= HWRITE;
            sl_dp_idx   <= HADDR[11:2];
        end
    end
    assign HRDATA = (sl_dp_valid && !sl_dp_write) ? mem[sl_dp_idx] : '0;

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic start_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] n);
        cyc();
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = n;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_offer: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) cyc();
        #1;
        total++;
        if ({cmd_ready, wr_ready, rd_valid, done, error, HSEL, HTRANS, HWRITE} !== 9'b1_0000_0_00_0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {cmd_ready, wr_ready, rd_valid, done, error, HSEL, HTRANS, HWRITE});
        end
        total++;
        if (HADDR !== 64'h0 || HWDATA !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr_data: HADDR=%h HWDATA=%h want 0", HADDR, HWDATA);
        end
        total++;
        if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'd2, 3'd1, 4'b0011, 1'b0}) begin
            bad++;
            $display("FAIL reset_const: HSIZE=%0d HBURST=%0d HPROT=%b HMASTLOCK=%b", HSIZE, HBURST, HPROT, HMASTLOCK);
        end
        cyc();
        HRESET = 1'b0;
        #1;
        total++;
        if (dbg_state !== IDLE || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: state=%0d cmd_ready=%b want IDLE/1", dbg_state, cmd_ready);
        end
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] wd [4];
        logic [1:0]    tr_exp [7];
        int            widx;
        logic          hs;
        wd     = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hDEAD_BEEF, 32'h0123_4567};
        tr_exp = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE, HTRANS_IDLE};
        widx = 0;
        hs = 1'b0;
        wr_valid = 1'b1;
        wr_data  = wd[0];
        start_cmd(1'b1, 64'h100, 16'd4);
        for (int k = 0; k < 7; k++) begin
            cyc();
            cmd_valid = 1'b0;
            if (hs) widx++;
            wr_data = (widx < 4) ? wd[widx] : '0;
            #1;
            hs = wr_valid && wr_ready;
            total++;
            if (HTRANS !== tr_exp[k] || HSEL !== (tr_exp[k] != HTRANS_IDLE)) begin
                bad++;
                $display("FAIL wr_htrans k=%0d: got %b/%b want %b", k, HTRANS, HSEL, tr_exp[k]);
            end
            if (k < 4) begin
                total++;
                if (HADDR !== 64'h100 + 64'(4 * k) || HWRITE !== 1'b1) begin
                    bad++;
                    $display("FAIL wr_haddr k=%0d: got %h/%b want %h/1", k, HADDR, HWRITE, 64'h100 + 64'(4 * k));
                end
            end
            if (k >= 1 && k <= 4) begin
                total++;
                if (HWDATA !== wd[k-1]) begin
                    bad++;
                    $display("FAIL wr_hwdata k=%0d: got %h want %h", k, HWDATA, wd[k-1]);
                end
            end
            total++;
            if (done !== 1'(k == 5) || error !== 1'b0) begin
                bad++;
                $display("FAIL wr_done k=%0d: got %b/%b want %b/0", k, done, error, k == 5);
            end
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(wd[i]);
    endtask

    task automatic test_read_back(input logic [AW-1:0] a, input int n);
        int            nrd;
        logic [DW-1:0] e;
        nrd = 0;
        start_cmd(1'b0, a, LW'(n));
        for (int k = 0; k < n + 3; k++) begin
            cyc();
            cmd_valid = 1'b0;
            #1;
            total++;
            if (rd_valid !== 1'(k >= 1 && k <= n)) begin
                bad++;
                $display("FAIL rd_valid k=%0d: got %b want %b", k, rd_valid, (k >= 1 && k <= n));
            end
            if (rd_valid === 1'b1) begin
                nrd++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_data k=%0d: got %h want nothing", k, rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        bad++;
                        $display("FAIL rd_data k=%0d: got %h want %h", k, rd_data, e);
                    end
                end
            end
            if (k < n) begin
                total++;
                if (HTRANS !== (k == 0 ? HTRANS_NONSEQ : HTRANS_SEQ) || HADDR !== a + 64'(4 * k) || HWRITE !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_addr k=%0d: got %b %h %b want %h", k, HTRANS, HADDR, HWRITE, a + 64'(4 * k));
                end
            end
            total++;
            if (done !== 1'(k == n + 1)) begin
                bad++;
                $display("FAIL rd_done k=%0d: got %b want %b", k, done, k == n + 1);
            end
        end
        total++;
        if (nrd != n) begin
            bad++;
            $display("FAIL rd_count: got %0d want %0d", nrd, n);
        end
    endtask

    task automatic test_write_busy();
        logic [DW-1:0] wd [3];
        logic          wv [7];
        logic [1:0]    tr_exp [7];
        logic [AW-1:0] ad_exp [5];
        logic [DW-1:0] hd_exp [5];
        int            widx;
        logic          hs;
        wd     = '{32'hE000_0000, 32'hE111_1111, 32'hE222_2222};
        wv     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tr_exp = '{HTRANS_NONSEQ, HTRANS_BUSY, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
        ad_exp = '{64'h100, 64'h104, 64'h104, 64'h104, 64'h108};
        hd_exp = '{32'hE000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE111_1111, 32'hE222_2222};
        widx = 0;
        hs = 1'b0;
        wr_data = wd[0];
        start_cmd(1'b1, 64'h100, 16'd3);
        for (int k = 0; k < 7; k++) begin
            cyc();
            cmd_valid = 1'b0;
            if (hs) widx++;
            wr_data  = (widx < 3) ? wd[widx] : '0;
            wr_valid = wv[k];
            #1;
            hs = wr_valid && wr_ready;
            total++;
            if (HTRANS !== tr_exp[k]) begin
                bad++;
                $display("FAIL busy_htrans k=%0d: got %b want %b", k, HTRANS, tr_exp[k]);
            end
            if (k < 5) begin
                total++;
                if (HADDR !== ad_exp[k]) begin
                    bad++;
                    $display("FAIL busy_haddr k=%0d: got %h want %h", k, HADDR, ad_exp[k]);
                end
            end
            if (k >= 1 && k <= 5) begin
                total++;
                if (HWDATA !== hd_exp[k-1]) begin
                    bad++;
                    $display("FAIL busy_hwdata k=%0d: got %h want %h", k, HWDATA, hd_exp[k-1]);
                end
            end
            total++;
            if (done !== 1'(k == 6)) begin
                bad++;
                $display("FAIL busy_done k=%0d: got %b want %b", k, done, k == 6);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] wd [4];
        logic          hr [9];
        logic [1:0]    tr_exp [9];
        logic [AW-1:0] ad_exp [7];
        logic [DW-1:0] hd_exp [7];
        int            widx;
        logic          hs;
        wd     = '{32'hF000_000F, 32'hF111_111E, 32'hF222_222D, 32'hF333_333C};
        hr     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tr_exp = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ,
                   HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
        ad_exp = '{64'h300, 64'h304, 64'h308, 64'h308, 64'h308, 64'h308, 64'h30C};
        hd_exp = '{32'hF000_000F, 32'hF111_111E, 32'hF111_111E, 32'hF111_111E,
                   32'hF111_111E, 32'hF222_222D, 32'hF333_333C};
        widx = 0;
        hs = 1'b0;
        wr_valid = 1'b1;
        wr_data  = wd[0];
        start_cmd(1'b1, 64'h300, 16'd4);
        for (int k = 0; k < 9; k++) begin
            cyc();
            cmd_valid = 1'b0;
            if (hs) widx++;
            wr_data = (widx < 4) ? wd[widx] : '0;
            HREADY  = hr[k];
            #1;
            hs = wr_valid && wr_ready;
            total++;
            if (HTRANS !== tr_exp[k]) begin
                bad++;
                $display("FAIL wait_htrans k=%0d: got %b want %b", k, HTRANS, tr_exp[k]);
            end
            if (k < 7) begin
                total++;
                if (HADDR !== ad_exp[k] || wr_ready !== hr[k]) begin
                    bad++;
                    $display("FAIL wait_haddr k=%0d: got %h/%b want %h/%b", k, HADDR, wr_ready, ad_exp[k], hr[k]);
                end
            end
            if (k >= 1 && k <= 7) begin
                total++;
                if (HWDATA !== hd_exp[k-1]) begin
                    bad++;
                    $display("FAIL wait_hwdata k=%0d: got %h want %h", k, HWDATA, hd_exp[k-1]);
                end
            end
            total++;
            if (done !== 1'(k == 8)) begin
                bad++;
                $display("FAIL wait_done k=%0d: got %b want %b", k, done, k == 8);
            end
        end
        wr_valid = 1'b0;
        HREADY   = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(wd[i]);
        test_read_back(64'h300, 4);
    endtask

    task automatic test_error();
        logic       hr [6];
        logic       hp [6];
        logic [1:0] tr_exp [6];
        int         issued;
        hr     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        hp     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tr_exp = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE, HTRANS_IDLE};
        issued = 0;
        wr_valid = 1'b1;
        wr_data  = 32'hC0DE_0000;
        start_cmd(1'b1, 64'h500, 16'd8);
        for (int k = 0; k < 6; k++) begin
            cyc();
            cmd_valid = 1'b0;
            wr_data = 32'hC0DE_0000 + 32'(k);
            HREADY  = hr[k];
            HRESP   = hp[k];
            #1;
            if (HTRANS[1] && HREADY) issued++;
            total++;
            if (HTRANS !== tr_exp[k]) begin
                bad++;
                $display("FAIL err_htrans k=%0d: got %b want %b", k, HTRANS, tr_exp[k]);
            end
            if (k < 3) begin
                total++;
                if (HADDR !== 64'h500 + 64'(4 * k)) begin
                    bad++;
                    $display("FAIL err_haddr k=%0d: got %h want %h", k, HADDR, 64'h500 + 64'(4 * k));
                end
            end
            if (k == 3) begin
                total++;
                if (wr_ready !== 1'b0 || HSEL !== 1'b0) begin
                    bad++;
                    $display("FAIL err_quiet: wr_ready=%b HSEL=%b want 0/0", wr_ready, HSEL);
                end
            end
            total++;
            if (done !== 1'(k == 4) || error !== 1'(k == 4)) begin
                bad++;
                $display("FAIL err_done k=%0d: got %b/%b want %b/%b", k, done, error, k == 4, k == 4);
            end
        end
        total++;
        if (issued != 2 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL err_issued: got %0d beats cmd_ready=%b want 2/1", issued, cmd_ready);
        end
        wr_valid = 1'b0;
        HRESP    = 1'b0;
        HREADY   = 1'b1;
        exp_q.push_back(32'hE000_0000);
        exp_q.push_back(32'hE111_1111);
        exp_q.push_back(32'hE222_2222);
        test_read_back(64'h100, 3);
    endtask

    task automatic test_zero_len();
        start_cmd(1'b1, 64'h700, 16'd0);
        cyc();
        cmd_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || error !== 1'b0 || HTRANS !== HTRANS_IDLE || dbg_state !== DONE) begin
            bad++;
            $display("FAIL zero_len_done: done=%b error=%b htrans=%b state=%0d want 1/0/00/DONE",
                     done, error, HTRANS, dbg_state);
        end
        cyc();
        #1;
        total++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_len_idle: done=%b cmd_ready=%b want 0/1", done, cmd_ready);
        end
    endtask

    task automatic test_1kb_boundary();
        logic [1:0] tr_exp [4];
`ifdef MPSOC_AHB3_DMA_1KB_SPLIT_EN
        tr_exp = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_NONSEQ, HTRANS_SEQ};
`else
        tr_exp = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ};
`endif
        start_cmd(1'b0, 64'h3F8, 16'd4);
        for (int k = 0; k < 6; k++) begin
            cyc();
            cmd_valid = 1'b0;
            #1;
            if (k < 4) begin
                total++;
                if (HTRANS !== tr_exp[k] || HADDR !== 64'h3F8 + 64'(4 * k)) begin
                    bad++;
                    $display("FAIL kb_htrans k=%0d: got %b %h want %b %h", k, HTRANS, HADDR, tr_exp[k],
                             64'h3F8 + 64'(4 * k));
                end
            end
            total++;
            if (done !== 1'(k == 5)) begin
                bad++;
                $display("FAIL kb_done k=%0d: got %b want %b", k, done, k == 5);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen_done;
        seen_done = 0;
        start_cmd(1'b0, 64'h100, 16'd8);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
        #1;
        total++;
        if (dbg_state !== IDLE || HTRANS !== HTRANS_IDLE || cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: state=%0d htrans=%b cmd_ready=%b rd_valid=%b want IDLE/00/1/0",
                     dbg_state, HTRANS, cmd_ready, rd_valid);
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            #1;
            if (done === 1'b1 || HTRANS !== HTRANS_IDLE) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL midrst_quiet: got %0d active cycles want 0", seen_done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_back(64'h100, 4);
        test_write_busy();
        test_wait_states();
        test_error();
        test_zero_len();
        test_1kb_boundary();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpsoc_ahb3_dma_master.md
Name: mpsoc_ahb3_dma_master

Overview:
- AHB3-Lite master that turns one command into a sequence of full-width transfers: start address plus beat count, read or write.
- Sits directly upstream of the AHB3 single-port SRAM slave and drives its HSEL/HADDR/HTRANS/HWDATA side.
- Write data arrives on a valid/ready stream; read data leaves on a valid-only stream.
- Used for memory preload and dump in MPSoC test and boot flows.

Parameters:
- HADDR_SIZE, 64, AHB address width.
- HDATA_SIZE, 32, AHB data width; power of two, 8..1024.
- LEN_SIZE, 16, width of the beat-count field.
- HPROT_VAL, 4'b0011, constant value driven on HPROT.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  HADDR_SIZE  start byte address; must be HDATA_SIZE/8 aligned.
- cmd_len  in  LEN_SIZE  beat count; 0 completes immediately.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted.
- wr_data  in  HDATA_SIZE  write beat data.
- rd_valid  out  1  read beat valid, one-cycle pulse, no backpressure.
- rd_data  out  HDATA_SIZE  read beat data.
- done  out  1  one-cycle pulse at command completion.
- error  out  1  qualifies done; 1 = aborted on HRESP ERROR.
- HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK  out  standard AHB3 widths  master outputs.
- HRDATA  in  HDATA_SIZE  read data.
- HREADY  in  1  bus ready.
- HRESP  in  1  slave response.

Behaviour:
- Reset (HRESET high at a HCLK edge): state IDLE; HTRANS=IDLE; HSEL=0; cmd_ready=1; wr_ready=0; rd_valid=0; done=0; error=0; HADDR=0; HWDATA=0; HWRITE=0.
- Reset mid-burst abandons the command with no done pulse.
- Constant outputs: HSIZE=$clog2(HDATA_SIZE/8), HBURST=INCR, HPROT=HPROT_VAL, HMASTLOCK=0.
- HSEL is 1 whenever HTRANS≠IDLE.
- States:
  - IDLE: cmd_ready=1. On accept, latch addr, len, write. len=0 goes to DONE; otherwise ADDR.
  - ADDR: drive address phases. A beat "issues" when HTRANS is NONSEQ/SEQ and HREADY=1. HADDR increments by HDATA_SIZE/8 per issued beat. First beat is NONSEQ, later beats SEQ.
  - Write data: wr_ready = (state==ADDR) & HREADY & beats_left>0. The first beat is not presented (HTRANS=IDLE) until wr_valid=1. A later beat with wr_valid=0 drives BUSY; address and beat count are held. An accepted beat is registered and driven on HWDATA in the following data phase, held until HREADY=1.
  - LAST: the final beat has issued; wait for its data phase (HREADY=1), with HTRANS=IDLE, then go to DONE.
  - DONE: pulse done (and error if set) for 1 cycle, then IDLE. cmd_ready=0 in every state except IDLE.
- Read: rd_valid pulses in the cycle HREADY=1 completes a read data phase; rd_data=HRDATA. Total latency is 1 cycle after address-phase issue when the slave has zero wait states.
- Address/control outputs change only when HREADY=1, except for the forced IDLE on error.
- Error: on HRESP=1 & HREADY=0 (first error cycle), drive HTRANS=IDLE in the next cycle, discard remaining beats, set error, go to DONE after the second error cycle. No rd_valid for the errored beat.
- Beat counter: LEN_SIZE bits, decremented per issued beat. cmd_len=2^LEN_SIZE-1 must complete without wrap.
- HADDR wraps modulo 2^HADDR_SIZE silently.

Optional Feature:
- Macro: MPSOC_AHB3_DMA_1KB_SPLIT_EN.
- Defined: a beat whose address has bits [9:0]==0 and is not the first beat is issued as NONSEQ instead of SEQ (AHB 1KB boundary rule).
- Undefined: all non-first beats are SEQ; cheaper, valid only for slaves that ignore the rule, such as the SRAM slave.

Decomposition:
- HTRANS/HBURST/HSIZE/HRESP defines come from the existing mpsoc_pkg.sv.
- Add to mpsoc_pkg.sv: typedef enum {IDLE, ADDR, LAST, DONE} dma_state_t.
- Single module, no sub-module: address and data pipeline are two registers plus the FSM.

Test Plan:
- Write cmd addr=0x100, len=4, wr_valid always 1, zero-wait SRAM slave -> HTRANS NONSEQ,SEQ,SEQ,SEQ at 0x100..0x10C; done 6 cycles after accept; error=0.
- Read back same range -> rd_data sequence equals written data; 4 rd_valid pulses, the first one 2 cycles after accept.
- Write len=3 with wr_valid low for 2 cycles after beat 1 -> HTRANS NONSEQ,BUSY,BUSY,SEQ,SEQ; HADDR held at 0x104 during BUSY.
- Slave holds HREADY=0 for 3 cycles on beat 2 -> HADDR/HTRANS/HWDATA stable throughout; all data correct.
- HRESP ERROR on beat 2 of len=8 -> HTRANS=IDLE the next cycle; done & error pulse; no further transfers; next command accepted normally.
- With MPSOC_AHB3_DMA_1KB_SPLIT_EN, addr=0x3F8, len=4 -> NONSEQ at 0x3F8 and at 0x400; without the macro, SEQ at 0x400.
